// File: rtl/prog_seq_detector.sv
// Runtime-programmable Mealy serial-pattern detector with per-bit mask,
// overlap/non-overlap mode and a saturating match counter.
module prog_seq_detector #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b00010101,
    parameter int                 DEF_LEN     = 5,
    parameter logic [MAX_LEN-1:0] DEF_MASK    = 8'b00011111,
    parameter logic               DEF_OVERLAP = 1'b1,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x_valid,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [MAX_LEN-1:0] cfg_mask,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic               z_q,
    output logic [CNT_W-1:0]   match_count,
    output logic               hunting
);

    typedef enum logic {FILL = 1'b0, HUNT = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d, mask_q, mask_d;
    logic [LEN_W-1:0]   len_q, len_d, len_new, fill_q, fill_d, fill_inc;
    logic               ov_q, ov_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] w;
    logic               hit;
    logic [CNT_W-1:0]   cnt_d;

    assign w       = {hist_q, x};
    assign hunting = (state_q == HUNT);
    assign z       = x_valid & ~cfg_load & ~reset & (state_q == HUNT) & hit;

    // Positions at or beyond the active length never block a hit.
    always_comb begin
        hit = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < len_q) && mask_q[i] && (w[i] != pat_q[i])) begin
                hit = 1'b0;
            end
        end
    end

    always_comb begin
        len_new = cfg_len;
        if (cfg_len == '0) begin
            len_new = LEN_W'(1);
        end else if (cfg_len > LEN_W'(MAX_LEN)) begin
            len_new = LEN_W'(MAX_LEN);
        end
    end

    assign fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        mask_d  = mask_q;
        len_d   = len_q;
        ov_d    = ov_q;
        if (cfg_load) begin
            pat_d   = cfg_pattern;
            mask_d  = cfg_mask;
            len_d   = len_new;
            ov_d    = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = (len_new == LEN_W'(1)) ? HUNT : FILL;
        end else if (x_valid) begin
            hist_d = w[MAX_LEN-2:0];
            if (z && !ov_q) begin
                fill_d  = '0;
                state_d = (len_q == LEN_W'(1)) ? HUNT : FILL;
            end else begin
                fill_d  = fill_inc;
                state_d = (fill_inc < len_q - LEN_W'(1)) ? FILL : HUNT;
            end
        end
    end

    always_comb begin
        cnt_d = match_count;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (z && (match_count != {CNT_W{1'b1}})) begin
            cnt_d = match_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            fill_q      <= '0;
            hist_q      <= '0;
            pat_q       <= DEF_PATTERN;
            mask_q      <= DEF_MASK;
            len_q       <= LEN_W'(DEF_LEN);
            ov_q        <= DEF_OVERLAP;
            match_count <= '0;
            z_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            hist_q      <= hist_d;
            pat_q       <= pat_d;
            mask_q      <= mask_d;
            len_q       <= len_d;
            ov_q        <= ov_d;
            match_count <= cnt_d;
            z_q         <= z;
        end
    end

endmodule

// File: tb/tb_prog_seq_detector.sv
// Directed bench for prog_seq_detector: default, mask, length, gap, load,
// saturation and reset scenarios against hand-computed expectations.
module tb_prog_seq_detector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       x_valid = 1'b0, x = 1'b0, cfg_load = 1'b0, cnt_clr = 1'b0;
    logic [7:0] cfg_pattern = 8'b00010101, cfg_mask = 8'b00011111;
    logic [3:0] cfg_len = 4'd5;
    logic       cfg_overlap = 1'b1;
    logic       z, z_q, hunting, z2, z_q2, hunting2;
    logic [7:0] match_count;
    logic [1:0] match_count2;
    int         n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    prog_seq_detector u_dut (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .z(z), .z_q(z_q),
        .match_count(match_count), .hunting(hunting)
    );

    prog_seq_detector #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .z(z2), .z_q(z_q2),
        .match_count(match_count2), .hunting(hunting2)
    );

    // Inputs change just after the falling edge; z is observed 1 ns later.
    task automatic drive(input logic v, input logic b, input logic ld, input logic clr);
        @(negedge clk);
        x_valid = v; x = b; cfg_load = ld; cnt_clr = clr;
        #1;
    endtask

    task automatic load_cfg(input logic [7:0] pat, input logic [7:0] msk,
                            input logic [3:0] len, input logic ov);
        cfg_pattern = pat; cfg_mask = msk; cfg_len = len; cfg_overlap = ov;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        x_valid = 1'b1; x = 1'b1;
        #1;
        n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL reset_z: got %b expected 0", z); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (z_q !== 1'b0) begin n_err++; $display("FAIL reset_z_q: got %b expected 0", z_q); end
        n_cmp++; if (match_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", match_count); end
        n_cmp++; if (hunting !== 1'b0) begin n_err++; $display("FAIL reset_hunting: got %b expected 0", hunting); end
        @(negedge clk);
        reset = 1'b0; x_valid = 1'b0; x = 1'b0;
    endtask

    task automatic test_defaults();
        logic [0:6] s = 7'b1010101;
        logic [0:6] e = 7'b0000101;
        logic prev = 1'b0;
        load_cfg(8'b00010101, 8'b00011111, 4'd5, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, s[i], 1'b0, 1'b0);
            n_cmp++; if (z !== e[i]) begin n_err++; $display("FAIL defaults_z[%0d]: got %b expected %b", i + 1, z, e[i]); end
            n_cmp++; if (z_q !== prev) begin n_err++; $display("FAIL defaults_z_q[%0d]: got %b expected %b", i + 1, z_q, prev); end
            prev = e[i];
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (z_q !== 1'b1) begin n_err++; $display("FAIL defaults_z_q_last: got %b expected 1", z_q); end
        n_cmp++; if (match_count !== 8'd2) begin n_err++; $display("FAIL defaults_count: got %0d expected 2", match_count); end
        n_cmp++; if (hunting !== 1'b1) begin n_err++; $display("FAIL defaults_hunting: got %b expected 1", hunting); end
    endtask

    task automatic test_overlap_mode();
        logic [0:8] s = 9'b101010101;
        logic [0:8] e;
        for (int p = 0; p < 2; p++) begin
            e = (p == 1) ? 9'b000010101 : 9'b000010000;
            load_cfg(8'b00010101, 8'b00011111, 4'd5, p[0]);
            for (int i = 0; i < 9; i++) begin
                drive(1'b1, s[i], 1'b0, 1'b0);
                n_cmp++; if (z !== e[i]) begin n_err++; $display("FAIL overlap%0d_z[%0d]: got %b expected %b", p, i + 1, z, e[i]); end
            end
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (match_count !== ((p == 1) ? 8'd3 : 8'd1)) begin
                n_err++; $display("FAIL overlap%0d_count: got %0d expected %0d", p, match_count, (p == 1) ? 3 : 1);
            end
        end
    endtask

    task automatic test_mask();
        logic [0:11] s = 12'b1101_1001_1111;
        logic [0:11] e = 12'b0001_0001_0000;
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 0) load_cfg(8'b00001001, 8'b00001011, 4'd4, 1'b1);
            drive(1'b1, s[i], 1'b0, 1'b0);
            n_cmp++; if (z !== e[i]) begin n_err++; $display("FAIL mask_z[%0d]: got %b expected %b", i, z, e[i]); end
        end
    endtask

    task automatic test_len_clamp();
        logic [0:3] s0 = 4'b1011;
        logic [0:3] e0 = 4'b1011;
        logic [0:7] s1 = 8'b10100101;
        logic [0:7] e1 = 8'b00000001;
        load_cfg(8'b00000001, 8'b00000001, 4'd0, 1'b1);
        n_cmp++; if (hunting !== 1'b1) begin n_err++; $display("FAIL len0_hunting: got %b expected 1", hunting); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, s0[i], 1'b0, 1'b0);
            n_cmp++; if (z !== e0[i]) begin n_err++; $display("FAIL len0_z[%0d]: got %b expected %b", i, z, e0[i]); end
        end
        load_cfg(8'b10100101, 8'b11111111, 4'd15, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, s1[i], 1'b0, 1'b0);
            n_cmp++; if (z !== e1[i]) begin n_err++; $display("FAIL len15_z[%0d]: got %b expected %b", i, z, e1[i]); end
        end
    endtask

    task automatic test_gaps();
        logic [0:4] s = 5'b10101;
        load_cfg(8'b00010101, 8'b00011111, 4'd5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, s[i], 1'b0, 1'b0);
            n_cmp++; if (z !== (i == 4)) begin n_err++; $display("FAIL gaps_z[%0d]: got %b expected %b", i, z, i == 4); end
            if (i < 4) begin
                for (int g = 0; g < 3; g++) begin
                    drive(1'b0, 1'b1, 1'b0, 1'b0);
                    n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL gaps_idle_z[%0d.%0d]: got %b expected 0", i, g, z); end
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (match_count !== 8'd1) begin n_err++; $display("FAIL gaps_count: got %0d expected 1", match_count); end
    endtask

    task automatic test_load_discard();
        logic [0:8] s = 9'b1010_10101;
        logic [0:8] e = 9'b0000_00001;
        load_cfg(8'b00010101, 8'b00011111, 4'd5, 1'b1);
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                drive(1'b1, 1'b1, 1'b1, 1'b0);
                n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL load_cycle_z: got %b expected 0", z); end
            end
            drive(1'b1, s[i], 1'b0, 1'b0);
            n_cmp++; if (z !== e[i]) begin n_err++; $display("FAIL load_z[%0d]: got %b expected %b", i, z, e[i]); end
        end
    endtask

    task automatic test_saturate();
        logic [0:12] s = 13'b1010101010101;
        load_cfg(8'b00010101, 8'b00011111, 4'd5, 1'b1);
        for (int i = 0; i < 13; i++) drive(1'b1, s[i], 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (match_count2 !== 2'd3) begin n_err++; $display("FAIL sat_count2: got %0d expected 3", match_count2); end
        n_cmp++; if (match_count !== 8'd5) begin n_err++; $display("FAIL sat_count8: got %0d expected 5", match_count); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL clr_match_z: got %b expected 1", z); end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (match_count2 !== 2'd0) begin n_err++; $display("FAIL clr_count2: got %0d expected 0", match_count2); end
        n_cmp++; if (match_count !== 8'd0) begin n_err++; $display("FAIL clr_count8: got %0d expected 0", match_count); end
    endtask

    task automatic test_reset_mid();
        logic [0:3] s = 4'b1010;
        logic [0:3] e = 4'b0010;
        logic [0:6] s2 = 7'b1010101;
        logic [0:6] e2 = 7'b0000101;
        load_cfg(8'b00000101, 8'b00000111, 4'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, s[i], 1'b0, 1'b0);
            n_cmp++; if (z !== e[i]) begin n_err++; $display("FAIL rstmid_pre_z[%0d]: got %b expected %b", i, z, e[i]); end
        end
        @(negedge clk);
        x_valid = 1'b1; x = 1'b1; reset = 1'b1;
        #1;
        n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL rstmid_z: got %b expected 0", z); end
        n_cmp++; if (match_count !== 8'd0) begin n_err++; $display("FAIL rstmid_count: got %0d expected 0", match_count); end
        n_cmp++; if (hunting !== 1'b0) begin n_err++; $display("FAIL rstmid_hunting: got %b expected 0", hunting); end
        @(negedge clk);
        reset = 1'b0; x_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, s2[i], 1'b0, 1'b0);
            n_cmp++; if (z !== e2[i]) begin n_err++; $display("FAIL rstmid_post_z[%0d]: got %b expected %b", i, z, e2[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_overlap_mode();
        test_mask();
        test_len_clamp();
        test_gaps();
        test_load_discard();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
